// File: rtl/median_window_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// median_window_fetch: reads a raster image word by word, keeps two rows in
// line buffers and streams 3-row word triplets through a 2-entry output FIFO.
// Rev 1.0
// ----------------------------------------------------------------------------
module median_window_fetch #(
  parameter int MEM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int IMG_WORDS      = 4,
  parameter int IMG_ROWS       = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     mem_raddr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata,
  output logic [MEM_DATA_WIDTH-1:0] word0,
  output logic [MEM_DATA_WIDTH-1:0] word1,
  output logic [MEM_DATA_WIDTH-1:0] word2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last_col,
  output logic                      out_last_row
);

  localparam int CW = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam int RW = $clog2(IMG_ROWS);
  localparam int DW = MEM_DATA_WIDTH;
  localparam int FW = 3 * DW + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [CW-1:0] c_col_last = CW'(IMG_WORDS - 1);
  localparam logic [RW-1:0] c_row_last = RW'(IMG_ROWS - 1);

  logic [1:0]            r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  r_pend;
  logic [CW-1:0]         r_pend_col;
  logic [RW-1:0]         r_pend_row;
  logic                  r_done;
  logic [DW-1:0]         r_lb0 [0:(1<<CW)-1];
  logic [DW-1:0]         r_lb1 [0:(1<<CW)-1];
  logic [FW-1:0]         r_fifo [0:1];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_room;
  logic          w_col_last;
  logic [2:0]    w_occ;
  logic [FW-1:0] w_head;

  assign w_pop      = out_valid & out_ready;
  assign w_push     = r_pend && (r_pend_row > RW'(1));
  assign w_col_last = (r_col == c_col_last);
  // Entries already held plus the one landing this cycle, minus the one leaving.
  assign w_occ      = 3'(r_count) + 3'(r_pend) - 3'(w_pop);
  assign w_room     = (w_occ < 3'd2);

  assign mem_rd_en  = (r_state == S_PRIME) || ((r_state == S_STREAM) && w_room);
  assign mem_raddr  = mem_rd_en ? r_addr : r_last_addr;

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign out_valid    = (r_count != 2'd0);
  assign w_head       = r_fifo[r_rd_ptr];
  assign word0        = w_head[FW-1 -: DW];
  assign word1        = w_head[FW-1-DW -: DW];
  assign word2        = w_head[FW-1-2*DW -: DW];
  assign out_last_col = w_head[1];
  assign out_last_row = w_head[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_pend      <= 1'b0;
      r_pend_col  <= '0;
      r_pend_row  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_pend <= mem_rd_en;
      if (mem_rd_en) begin
        r_pend_col  <= r_col;
        r_pend_row  <= r_row;
        r_last_addr <= r_addr;
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !r_done) begin
            r_state <= S_PRIME;
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
          end
        end
        S_PRIME: begin
          if (w_col_last && (r_row == RW'(1))) r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (mem_rd_en && w_col_last && (r_row == c_row_last)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && out_last_col && out_last_row) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {r_lb0[r_pend_col], r_lb1[r_pend_col], mem_rdata,
                             r_pend_col == c_col_last, r_pend_row == c_row_last};
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  // Line buffers roll up one row on every return from row 2 onward.
  always_ff @(posedge clk) begin
    if (r_pend) begin
      if (r_pend_row == RW'(0)) begin
        r_lb0[r_pend_col] <= mem_rdata;
      end else if (r_pend_row == RW'(1)) begin
        r_lb1[r_pend_col] <= mem_rdata;
      end else begin
        r_lb0[r_pend_col] <= r_lb1[r_pend_col];
        r_lb1[r_pend_col] <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_median_window_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for median_window_fetch: default 4x6 frame against a triplet list
// built straight from the memory image, plus a 1x3 minimum-frame instance.
module tb_median_window_fetch;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int W  = 4;
  localparam int R  = 6;
  localparam int NT = (R - 2) * W;
  localparam int TW = 3 * DW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, mem_rd_en, out_valid, out_last_col, out_last_row;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata, word0, word1, word2;
  logic [DW-1:0] mem [0:R*W-1];

  logic b_start = 1'b0;
  logic b_ready = 1'b0;
  logic b_busy, b_done, b_rd_en, b_valid, b_last_col, b_last_row;
  logic [AW-1:0] b_raddr;
  logic [DW-1:0] b_rdata, b_w0, b_w1, b_w2;
  logic [DW-1:0] mem_b [0:2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= (int'(mem_raddr) < R*W) ? mem[mem_raddr] : '0;
    if (b_rd_en)   b_rdata   <= (int'(b_raddr) < 3) ? mem_b[b_raddr] : '0;
  end

  median_window_fetch #(.MEM_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WORDS(W), .IMG_ROWS(R)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .word0(word0), .word1(word1), .word2(word2), .out_valid(out_valid),
    .out_ready(out_ready), .out_last_col(out_last_col), .out_last_row(out_last_row)
  );

  median_window_fetch #(.MEM_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WORDS(1), .IMG_ROWS(3)) dut_min (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_rd_en(b_rd_en), .mem_raddr(b_raddr), .mem_rdata(b_rdata),
    .word0(b_w0), .word1(b_w1), .word2(b_w2), .out_valid(b_valid),
    .out_ready(b_ready), .out_last_col(b_last_col), .out_last_row(b_last_row)
  );

  task automatic fill_mem(input bit fixed);
    for (int i = 0; i < R*W; i++) mem[i] = $urandom;
    if (fixed) begin
      for (int c = 0; c < W; c++) begin
        mem[c]       = {8'd160, 8'd171, 8'd164, 8'd142} ^ 32'(c);
        mem[W + c]   = {8'd123, 8'd141, 8'd149, 8'd154} ^ 32'(c);
        mem[2*W + c] = {8'd163, 8'd177, 8'd171, 8'd136} ^ 32'(c);
      end
    end
  endtask

  // mode 0: ready always high; 1: ready low for 10 cycles from first valid; 2: random ready
  task automatic run_frame(input int mode, input int abort_at, input bit start_on_done);
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] got, held, exp;
    int n, acc, first_valid, exp_addr, s_issued, dones;
    bit held_ok, fin, acc_last, acc_now;
    for (int r = 2; r < R; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back({mem[(r-2)*W+c], mem[(r-1)*W+c], mem[r*W+c], 1'(c == W-1), 1'(r == R-1)});
    n = 0; acc = 0; first_valid = -1; exp_addr = 0; s_issued = 0; dones = 0;
    held_ok = 0; fin = 0; acc_last = 0; held = '0;
    while (n < 400 && !fin) begin
      @(posedge clk); #1;
      if (abort_at > 0 && acc == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rd_en, out_valid, out_last_col, out_last_row, mem_raddr, word0, word1, word2} !== '0) begin
          errors++;
          $display("FAIL abort_reset: busy=%b done=%b rd=%b raddr=%0d valid=%b w0=%h w1=%h w2=%h, expected all zero",
                   busy, done, mem_rd_en, mem_raddr, out_valid, word0, word1, word2);
        end
        @(posedge clk); #1 rst = 1'b0;
        return;
      end
      start = (n == 0) || (acc_last && start_on_done) ||
              (mode == 2 && n > 1 && busy && $urandom_range(0, 9) == 0);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(n >= 2*W+3 && n < 2*W+13);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      got = {word0, word1, word2, out_last_col, out_last_row};
      if (mem_rd_en) begin
        checks++;
        if (exp_addr >= R*W || mem_raddr !== AW'(exp_addr) || (exp_addr == 0 && n != 1)) begin
          errors++;
          $display("FAIL read_addr: cycle %0d got addr %0d, expected addr %0d (first read at cycle 1)", n, mem_raddr, exp_addr);
        end
        if (exp_addr >= 2*W) s_issued++;
        exp_addr++;
      end
      if (out_valid && first_valid < 0) begin
        first_valid = n;
        if (mode == 0) begin
          checks++;
          if (n != 2*W+3) begin
            errors++;
            $display("FAIL first_valid: got cycle %0d, expected cycle %0d", n, 2*W+3);
          end
        end
      end
      if (held_ok) begin
        checks++;
        if (!out_valid || got !== held) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b %h, expected valid=1 %h", out_valid, got, held);
        end
      end
      held_ok = out_valid && !out_ready;
      held = got;
      checks++;
      if (done !== acc_last || (acc_last && busy !== 1'b0)) begin
        errors++;
        $display("FAIL done_pulse: cycle %0d got done=%b busy=%b, expected done=%b busy=0", n, done, busy, acc_last);
      end
      if (done) dones++;
      fin = acc_last;
      acc_now = out_valid && out_ready;
      if (acc_now) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL triplet_extra: got %h, expected no more triplets", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL triplet %0d: got %h, expected %h", acc, got, exp);
          end
        end
        acc++;
        if (mode == 0) begin
          checks++;
          if (n != 2*W+2+acc) begin
            errors++;
            $display("FAIL no_bubble: triplet %0d accepted at cycle %0d, expected %0d", acc, n, 2*W+2+acc);
          end
        end
      end
      acc_last = acc_now && (acc == NT);
      checks++;
      if (s_issued - acc > 2) begin
        errors++;
        $display("FAIL outstanding: got %0d stream reads ahead of accepts, expected at most 2", s_issued - acc);
      end
      if (mode == 1 && n == 2*W+12) begin
        checks++;
        if (mem_rd_en !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_reads: got rd_en=%b valid=%b, expected rd_en=0 valid=1", mem_rd_en, out_valid);
        end
      end
      n++;
    end
    checks++;
    if (!fin || dones != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_end: got finished=%b dones=%0d leftover=%0d, expected 1/1/0", fin, dones, exp_q.size());
    end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: got busy=%b rd_en=%b valid=%b, expected 0/0/0", busy, mem_rd_en, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, mem_rd_en, out_valid, out_last_col, out_last_row} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 000000", {busy, done, mem_rd_en, out_valid, out_last_col, out_last_row});
    end
    checks++;
    if (mem_raddr !== '0 || {word0, word1, word2} !== '0) begin
      errors++;
      $display("FAIL reset_data: got raddr=%0d words=%h_%h_%h, expected zero", mem_raddr, word0, word1, word2);
    end
    checks++;
    if ({b_busy, b_done, b_rd_en, b_valid, b_last_col, b_last_row} !== 6'b0) begin
      errors++;
      $display("FAIL reset_min: got %b, expected 000000", {b_busy, b_done, b_rd_en, b_valid, b_last_col, b_last_row});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    fill_mem(1'b1);
    run_frame(0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_mem(1'b0);
    run_frame(1, 0, 1'b0);
  endtask

  task automatic test_random_ready();
    for (int f = 0; f < 3; f++) begin
      fill_mem(1'b0);
      run_frame(2, 0, 1'b1);
    end
  endtask

  task automatic test_reset_abort();
    fill_mem(1'b0);
    run_frame(0, 5, 1'b0);
    fill_mem(1'b0);
    run_frame(0, 0, 1'b0);
  endtask

  task automatic test_min_frame();
    int n, reads, trips, done_n, acc_n;
    for (int i = 0; i < 3; i++) mem_b[i] = $urandom;
    n = 0; reads = 0; trips = 0; done_n = -1; acc_n = -10;
    b_ready = 1'b1;
    while (n < 40 && done_n < 0) begin
      @(posedge clk); #1 b_start = (n == 0);
      @(negedge clk);
      if (b_rd_en) begin
        checks++;
        if (reads > 2 || b_raddr !== AW'(reads)) begin
          errors++;
          $display("FAIL min_read: got addr %0d, expected addr %0d (max 3 reads)", b_raddr, reads);
        end
        reads++;
      end
      if (b_valid && b_ready) begin
        checks++;
        if ({b_w0, b_w1, b_w2, b_last_col, b_last_row} !== {mem_b[0], mem_b[1], mem_b[2], 2'b11} || trips != 0) begin
          errors++;
          $display("FAIL min_triplet: got %h_%h_%h lc=%b lr=%b, expected %h_%h_%h lc=1 lr=1",
                   b_w0, b_w1, b_w2, b_last_col, b_last_row, mem_b[0], mem_b[1], mem_b[2]);
        end
        trips++;
        acc_n = n;
      end
      if (b_done) done_n = n;
      n++;
    end
    checks++;
    if (reads != 3 || trips != 1 || done_n != acc_n + 1) begin
      errors++;
      $display("FAIL min_done: got reads=%0d triplets=%0d done_cycle=%0d accept_cycle=%0d, expected 3/1/accept+1",
               reads, trips, done_n, acc_n);
    end
    @(posedge clk); #1 b_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_ready();
    test_reset_abort();
    test_min_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
